clause_mem_port_arbiter: RTL
============================

// Module: clause_mem_port_arbiter
// PURPOSE
//  Shares the single-port clause-table RAM between two requesters: the host
//  load path (AXI4 memory controller, clause_axi_* side) and the solver engine.
//  - Grants at most one access per cycle.
//  - The solver has fixed priority, with a starvation guard for the host.
//  - Tracks in-flight reads and returns each read's data to the requester that
//    issued it.
//  Sits between the AXI4 memory controller / solver core and the clause RAM.
// PARAMETERS
//  ADDR_W        12   clause-table word address width
//  DATA_W        480  clause word width ((11+1)*(3-1)*20)
//  RD_LATENCY    1    RAM read latency in cycles, valid range 1..4
//  STARVE_LIMIT  4    consecutive host-denied cycles before the host is forced ahead
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_ni         in   1       reset, asynchronous, active-low
//  host_req_i     in   1       host access request
//  host_we_i      in   1       host write (1) / read (0)
//  host_addr_i    in   ADDR_W  host word address
//  host_wdata_i   in   DATA_W  host write data
//  host_gnt_o     out  1       host request accepted this cycle
//  host_rvalid_o  out  1       host read data valid
//  host_rdata_o   out  DATA_W  host read data
//  slv_req_i      in   1       solver access request
//  slv_we_i       in   1       solver write / read
//  slv_addr_i     in   ADDR_W  solver word address
//  slv_wdata_i    in   DATA_W  solver write data
//  slv_gnt_o      out  1       solver request accepted this cycle
//  slv_rvalid_o   out  1       solver read data valid
//  slv_rdata_o    out  DATA_W  solver read data
//  mem_en_o       out  1       RAM enable
//  mem_we_o       out  1       RAM write enable
//  mem_addr_o     out  ADDR_W  RAM address
//  mem_wdata_o    out  DATA_W  RAM write data
//  mem_rdata_i    in   DATA_W  RAM read data, RD_LATENCY cycles after mem_en_o & ~mem_we_o
//  host_starved_o out  1       starvation override active (debug/perf)
// BEHAVIOUR
//  Reset (async, rst_ni=0): starve_cnt=0, tag pipe cleared.
//   All gnt/rvalid/mem_en/mem_we/host_starved outputs are 0; rdata outputs are 0.
//  Handshake: an access is accepted when req & gnt. Each requester holds
//   req/we/addr/wdata stable until gnt. gnt is combinational from req and state.
//  Arbitration:
//   - If host_starved_o=1 and host_req_i=1: grant host.
//   - Else if slv_req_i=1: grant solver.
//   - Else if host_req_i=1: grant host.
//   - Never both grants in one cycle. No grant without the matching req.
//  Starvation counter:
//   - host_req_i & ~host_gnt_o -> starve_cnt++ (saturates at STARVE_LIMIT).
//   - host_gnt_o, or ~host_req_i -> starve_cnt=0.
//   - host_starved_o = (starve_cnt == STARVE_LIMIT), registered state.
//  RAM drive (combinational, same cycle as the grant):
//   mem_en_o = any gnt; mem_we/addr/wdata are muxed from the winner.
//   With no grant, mem_en_o=0 and mem_we_o=0.
//  Read return:
//   - Each accepted read pushes {valid=1, id} into a RD_LATENCY-deep tag shift
//     register. Writes and idle cycles push valid=0.
//   - At the pipe output, valid&id==HOST -> host_rvalid_o=1 and
//     host_rdata_o=mem_rdata_i; likewise for the solver.
//   - rdata outputs hold their last value otherwise.
//   - Reads are returned strictly in issue order. Fully pipelined: one read may
//     be issued per cycle, back-to-back, with no bubbles.
//  Write-then-read to the same address in consecutive cycles returns the new
//   data; the RAM is write-first and the arbiter adds no forwarding.
//  Reset mid-operation flushes the tag pipe: no rvalid for any read in flight.
// STRUCTURE
//  Package sat_mem_pkg:
//   - CLAUSE_ADDR_W=12, CLAUSE_DATA_W=480.
//   - typedef enum logic {REQ_HOST=1'b0, REQ_SLV=1'b1} req_id_t.
//   - typedef struct {logic vld; req_id_t id;} rd_tag_t.
//  Sub-module rd_tag_pipe: parameterised-depth shift register of rd_tag_t with
//   async clear. The grant logic, starvation counter and output demux stay in
//   this top module.
// TESTING
//  1 Host-only read @0x008, RD_LATENCY=1 -> host_gnt_o same cycle.
//    host_rvalid_o=1 exactly 1 cycle later, host_rdata_o=RAM[0x008].
//    slv_rvalid_o stays 0.
//  2 Both req the same cycle (host rd 0x010, slv rd 0x020) -> slv_gnt_o first,
//    host_gnt_o the next cycle. Returns arrive in order: slv then host, each
//    with its own data.
//  3 Solver requests every cycle, host holds a write to 0x030 -> host denied 4
//    cycles, host_starved_o=1 in cycle 5. Host is granted in cycle 5 and
//    starve_cnt returns to 0.
//  4 Host wr 0x040=DEAD_BEEF.. then slv rd 0x040 back-to-back ->
//    slv_rdata_o=DEAD_BEEF..
//    mem_we_o=1 in cycle 1 only.
//  5 Three back-to-back slv reads with RD_LATENCY=3 -> three consecutive
//    slv_rvalid_o pulses starting 3 cycles after the first grant.
//  6 Assert rst_ni=0 with 2 reads in flight -> all outputs 0 asynchronously.
//    No rvalid after release; the next request is granted normally.

Source files
------------

// File: rtl/clause_mem_port_arbiter_pkg.sv
// Shared types and sizes for the clause-table RAM port arbiter.
package sat_mem_pkg;

    localparam int CLAUSE_ADDR_W = 12;
    localparam int CLAUSE_DATA_W = 480;

    // Identifies which requester issued a read, so its data can be routed back.
    typedef enum logic {
        REQ_HOST = 1'b0,
        REQ_SLV  = 1'b1
    } req_id_t;

    // One slot of the read-return tag pipe.
    typedef struct packed {
        logic    vld;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/clause_mem_port_arbiter_if.sv
// Requester-side RAM access bus: request/grant handshake plus read return.
interface clause_mem_port_arbiter_if
    import sat_mem_pkg::*;
#(
    parameter int ADDR_W = CLAUSE_ADDR_W,
    parameter int DATA_W = CLAUSE_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    // Requester side (host load path or solver core).
    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    // Arbiter side.
    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/clause_mem_port_arbiter_rd_tag_pipe.sv
// Delay line of read tags matching the RAM read latency; cleared on reset so
// reads in flight at reset never produce a return.
module rd_tag_pipe
    import sat_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);
    rd_tag_t stage [DEPTH];

    // Shift one tag per cycle; the last stage lines up with RAM read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/clause_mem_port_arbiter.sv
// Shares the single-port clause RAM between the host load path and the solver.
// Solver has fixed priority; the host is forced ahead after STARVE_LIMIT
// consecutive denied cycles. Read data is routed back by issue-time tag.
module clause_mem_port_arbiter
    import sat_mem_pkg::*;
#(
    parameter int ADDR_W       = CLAUSE_ADDR_W,
    parameter int DATA_W       = CLAUSE_DATA_W,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    clause_mem_port_arbiter_if.slave   host,
    clause_mem_port_arbiter_if.slave   slv,
    output logic                       mem_en_o,
    output logic                       mem_we_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    input  logic [DATA_W-1:0]          mem_rdata_i,
    output logic                       host_starved_o
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_cnt;
    logic              host_gnt;
    logic              slv_gnt;
    rd_tag_t           tag_in;
    rd_tag_t           tag_out;
    logic              host_hit;
    logic              slv_hit;
    logic [DATA_W-1:0] host_rdata_q;
    logic [DATA_W-1:0] slv_rdata_q;

    assign host_starved_o = (starve_cnt == CNT_MAX);

    // Grant selection: starved host first, then solver, then host; nothing in reset.
    always_comb begin
        host_gnt = 1'b0;
        slv_gnt  = 1'b0;
        if (rst_ni) begin
            if (host_starved_o && host.req) begin
                host_gnt = 1'b1;
            end else if (slv.req) begin
                slv_gnt = 1'b1;
            end else if (host.req) begin
                host_gnt = 1'b1;
            end
        end
    end

    // RAM drive muxed from the winner in the grant cycle.
    always_comb begin
        mem_en_o    = host_gnt | slv_gnt;
        mem_we_o    = 1'b0;
        mem_addr_o  = host.addr;
        mem_wdata_o = host.wdata;
        if (slv_gnt) begin
            mem_we_o    = slv.we;
            mem_addr_o  = slv.addr;
            mem_wdata_o = slv.wdata;
        end else if (host_gnt) begin
            mem_we_o = host.we;
        end
    end

    // Count consecutive denied host cycles, saturating at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (host.req && !host_gnt) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    assign tag_in.vld = mem_en_o & ~mem_we_o;
    assign tag_in.id  = slv_gnt ? REQ_SLV : REQ_HOST;

    rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign host_hit = tag_out.vld && (tag_out.id == REQ_HOST);
    assign slv_hit  = tag_out.vld && (tag_out.id == REQ_SLV);

    // Remember the last returned word per requester so rdata holds between returns.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            host_rdata_q <= '0;
            slv_rdata_q  <= '0;
        end else begin
            if (host_hit) host_rdata_q <= mem_rdata_i;
            if (slv_hit)  slv_rdata_q  <= mem_rdata_i;
        end
    end

    assign host.gnt    = host_gnt;
    assign host.rvalid = host_hit;
    assign host.rdata  = host_hit ? mem_rdata_i : host_rdata_q;
    assign slv.gnt     = slv_gnt;
    assign slv.rvalid  = slv_hit;
    assign slv.rdata   = slv_hit ? mem_rdata_i : slv_rdata_q;

endmodule
